// File: rtl/usb11_pkg.sv
// usb11_pkg: register map, token/status bit positions and transfer FSM states shared with usb11_regs users
package usb11_pkg;
    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_LEN    = 4'd5;
    localparam logic [3:0] ADDR_TOKEN  = 4'd6;
    localparam logic [3:0] ADDR_RXSTAT = 4'd7;
    localparam logic [3:0] ADDR_FIFO   = 4'd8;

    localparam int TOK_GO   = 31;
    localparam int TOK_IN   = 30;
    localparam int TOK_RESP = 29;
    localparam int TOK_DT   = 28;

    localparam int ST_BUSY = 31;
    localparam int ST_CRC  = 30;
    localparam int ST_TMO  = 29;
    localparam int ST_DONE = 28;

    localparam logic [7:0] PID_NAK = 8'h5A;
    localparam logic [6:0] MAX_LEN = 7'd64;

    typedef enum logic [3:0] {
        IDLE, FLUSH, LOAD, LEN, TOKEN, WAIT, RXRD, RXOUT, DONE
    } state_e;

    function automatic logic [31:0] token_word(input logic in_b, input logic rsp_b, input logic dt_b,
                                               input logic [7:0] pid, input logic [6:0] dev,
                                               input logic [3:0] ep);
        logic [31:0] w;
        w           = '0;
        w[TOK_GO]   = 1'b1;
        w[TOK_IN]   = in_b;
        w[TOK_RESP] = rsp_b;
        w[TOK_DT]   = dt_b;
        w[23:16]    = pid;
        w[15:9]     = dev;
        w[8:5]      = ep;
        return w;
    endfunction
endpackage

// File: rtl/usb11_xfer_ctrl.sv
// usb11_xfer_ctrl: sequences one USB 1.1 transfer (flush, load, token, status poll, IN drain) over the usb11_regs bus
//   clk_i, rst_i                     : clock, synchronous active-high reset
//   req_*                            : transfer request, latched when accepted in IDLE
//   tx_*                             : OUT payload bytes pushed into the TX FIFO
//   rx_*                             : IN payload bytes drained from the RX FIFO
//   done_o, resp_o, rx_cnt_o, err_o  : completion pulse; status {wdog, timeout, crc} held until next request
//   ctrl_cfg_i                       : control register image rewritten on every flush
//   m_*                              : register bus master, one single-cycle access per cycle at most
module usb11_xfer_ctrl
    import usb11_pkg::*;
#(
    parameter int          NAK_RETRIES = 3,
    parameter logic [15:0] WDOG_CYCLES = 16'd60000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [7:0]  req_pid_i,
    input  logic [6:0]  req_dev_i,
    input  logic [3:0]  req_ep_i,
    input  logic        req_in_i,
    input  logic        req_resp_i,
    input  logic        req_dt_i,
    input  logic [6:0]  req_len_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        done_o,
    output logic [7:0]  resp_o,
    output logic [6:0]  rx_cnt_o,
    output logic [2:0]  err_o,
    input  logic [7:0]  ctrl_cfg_i,
    output logic        m_sel_o,
    output logic [3:0]  m_addr_o,
    output logic [31:0] m_data_o,
    output logic        m_rd_o,
    output logic        m_wr_o,
    input  logic [31:0] m_data_i
);
    localparam logic [7:0] NAK_MAX = 8'(NAK_RETRIES);

    state_e      state_q, state_d;
    logic [7:0]  pid_q, pid_d;
    logic [6:0]  dev_q, dev_d;
    logic [3:0]  ep_q, ep_d;
    logic        in_q, in_d, rsp_q, rsp_d, dt_q, dt_d;
    logic [6:0]  len_q, len_d, idx_q, idx_d;
    logic [7:0]  retry_q, retry_d;
    logic [15:0] wdog_q, wdog_d;
    logic        first_q, first_d, ph_q, ph_d;
    logic [7:0]  rx_data_q, rx_data_d, resp_q, resp_d;
    logic [6:0]  rx_cnt_q, rx_cnt_d;
    logic [2:0]  err_q, err_d;
    logic        complete, nak_retry;
    logic [6:0]  st_cnt;
    logic        unused_ok;

    assign unused_ok = ^m_data_i[27:24];
    assign rx_data_o = rx_data_q;
    assign resp_o    = resp_q;
    assign rx_cnt_o  = rx_cnt_q;
    assign err_o     = err_q;
    assign m_sel_o   = m_rd_o | m_wr_o;

    always_comb begin
        state_d     = state_q;
        pid_d       = pid_q;
        dev_d       = dev_q;
        ep_d        = ep_q;
        in_d        = in_q;
        rsp_d       = rsp_q;
        dt_d        = dt_q;
        len_d       = len_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        wdog_d      = wdog_q;
        first_d     = first_q;
        ph_d        = ph_q;
        rx_data_d   = rx_data_q;
        resp_d      = resp_q;
        rx_cnt_d    = rx_cnt_q;
        err_d       = err_q;
        req_ready_o = 1'b0;
        tx_ready_o  = 1'b0;
        rx_valid_o  = 1'b0;
        done_o      = 1'b0;
        m_rd_o      = 1'b0;
        m_wr_o      = 1'b0;
        m_addr_o    = '0;
        m_data_o    = '0;
        // The status sampled in the first WAIT cycle answers no read of ours, so it is ignored.
        complete    = !first_q && !m_data_i[ST_BUSY] && m_data_i[ST_DONE];
        st_cnt      = (m_data_i[15:0] > 16'(MAX_LEN)) ? MAX_LEN : m_data_i[6:0];
        nak_retry   = in_q && m_data_i[23:16] == PID_NAK && !m_data_i[ST_CRC] && !m_data_i[ST_TMO]
                      && retry_q < NAK_MAX;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    pid_d    = req_pid_i;
                    dev_d    = req_dev_i;
                    ep_d     = req_ep_i;
                    in_d     = req_in_i;
                    rsp_d    = req_resp_i;
                    dt_d     = req_dt_i;
                    len_d    = (req_len_i > MAX_LEN) ? MAX_LEN : req_len_i;
                    retry_d  = '0;
                    resp_d   = '0;
                    rx_cnt_d = '0;
                    err_d    = '0;
                    state_d  = FLUSH;
                end
            end
            FLUSH: begin
                m_wr_o   = 1'b1;
                m_addr_o = ADDR_CTRL;
                m_data_o = {23'b0, 1'b1, ctrl_cfg_i};
                idx_d    = '0;
                state_d  = (!in_q && len_q != '0) ? LOAD : LEN;
            end
            LOAD: begin
                tx_ready_o = 1'b1;
                if (tx_valid_i) begin
                    m_wr_o   = 1'b1;
                    m_addr_o = ADDR_FIFO;
                    m_data_o = {24'b0, tx_data_i};
                    idx_d    = idx_q + 7'd1;
                    state_d  = (idx_q + 7'd1 == len_q) ? LEN : LOAD;
                end
            end
            LEN: begin
                m_wr_o   = 1'b1;
                m_addr_o = ADDR_LEN;
                m_data_o = {25'b0, len_q};
                state_d  = TOKEN;
            end
            TOKEN: begin
                m_wr_o   = 1'b1;
                m_addr_o = ADDR_TOKEN;
                m_data_o = token_word(in_q, rsp_q, dt_q, pid_q, dev_q, ep_q);
                wdog_d   = '0;
                first_d  = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                m_rd_o   = 1'b1;
                m_addr_o = ADDR_RXSTAT;
                first_d  = 1'b0;
                wdog_d   = wdog_q + 16'd1;
                if (complete) begin
                    resp_d   = m_data_i[23:16];
                    err_d    = {1'b0, m_data_i[ST_TMO], m_data_i[ST_CRC]};
                    rx_cnt_d = st_cnt;
                    idx_d    = '0;
                    retry_d  = nak_retry ? retry_q + 8'd1 : retry_q;
                    state_d  = nak_retry ? TOKEN : (in_q && st_cnt != '0) ? RXRD : DONE;
                end else if (wdog_q == WDOG_CYCLES - 16'd1) begin
                    err_d   = 3'b100;
                    state_d = DONE;
                end
            end
            RXRD: begin
                // Two phases: issue the FIFO read, then capture its data on the following cycle.
                m_rd_o    = !ph_q;
                m_addr_o  = ph_q ? 4'd0 : ADDR_FIFO;
                ph_d      = !ph_q;
                rx_data_d = ph_q ? m_data_i[7:0] : rx_data_q;
                state_d   = ph_q ? RXOUT : RXRD;
            end
            RXOUT: begin
                rx_valid_o = 1'b1;
                if (rx_ready_i) begin
                    idx_d   = idx_q + 7'd1;
                    state_d = (idx_q + 7'd1 < rx_cnt_q) ? RXRD : DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pid_q     <= '0;
            dev_q     <= '0;
            ep_q      <= '0;
            in_q      <= 1'b0;
            rsp_q     <= 1'b0;
            dt_q      <= 1'b0;
            len_q     <= '0;
            idx_q     <= '0;
            retry_q   <= '0;
            wdog_q    <= '0;
            first_q   <= 1'b0;
            ph_q      <= 1'b0;
            rx_data_q <= '0;
            resp_q    <= '0;
            rx_cnt_q  <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            pid_q     <= pid_d;
            dev_q     <= dev_d;
            ep_q      <= ep_d;
            in_q      <= in_d;
            rsp_q     <= rsp_d;
            dt_q      <= dt_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            wdog_q    <= wdog_d;
            first_q   <= first_d;
            ph_q      <= ph_d;
            rx_data_q <= rx_data_d;
            resp_q    <= resp_d;
            rx_cnt_q  <= rx_cnt_d;
            err_q     <= err_d;
        end
    end
endmodule
